// File: rtl/ram_access_ctrl.sv
// ============================================================================
//  Module   : ram_access_ctrl
//  Brief    : Byte-wide RAM sequencer serving a fetch port and a data port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_ctrl #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 2
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic [31:0]       f_rdata,
    output logic              f_done,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] DATA_RD = 3'd2;
    localparam logic [2:0] DATA_WR = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_last;
    logic              r_signed;
    logic              r_is_fetch;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [23:0]       r_asm;

    logic              w_access;
    logic              w_d_err;
    logic              w_f_err;
    logic [CNT_W-1:0]  w_d_last;
    logic [CNT_W-1:0]  w_sel;
    logic [31:0]       w_wshift;
    logic [31:0]       w_asm_next;
    logic [31:0]       w_ext;

    assign w_access = (r_state == FETCH) || (r_state == DATA_RD) || (r_state == DATA_WR);

    assign w_d_err = (d_size == 2'b11)
                   || ((d_size == 2'b01) && d_addr[0])
                   || ((d_size == 2'b10) && (d_addr[1:0] != 2'b00))
                   || ((d_addr >> ADDR_W) != 32'd0);
    assign w_f_err = (f_addr[1:0] != 2'b00) || ((f_addr >> ADDR_W) != 32'd0);

    always_comb begin
        w_d_last = CNT_W'(3);
        case (d_size)
            2'b00:   w_d_last = CNT_W'(0);
            2'b01:   w_d_last = CNT_W'(1);
            default: w_d_last = CNT_W'(3);
        endcase
    end

    // Big-endian: byte k of the access carries byte (N-1-k) of the item.
    assign w_sel    = r_last - r_cnt;
    assign w_wshift = r_wdata >> {w_sel, 3'b000};

    assign w_asm_next = {r_asm, ram_rdata};

    always_comb begin
        w_ext = w_asm_next;
        case (r_last)
            CNT_W'(0): w_ext = {{24{r_signed & w_asm_next[7]}},  w_asm_next[7:0]};
            CNT_W'(1): w_ext = {{16{r_signed & w_asm_next[15]}}, w_asm_next[15:0]};
            default:   w_ext = w_asm_next;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_signed   <= 1'b0;
            r_is_fetch <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_asm      <= '0;
            f_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (d_req) begin
                        r_base     <= d_addr[ADDR_W-1:0];
                        r_last     <= w_d_last;
                        r_signed   <= d_signed;
                        r_wdata    <= d_wdata;
                        r_is_fetch <= 1'b0;
                        r_err      <= w_d_err;
                        r_state    <= w_d_err ? DONE : (d_we ? DATA_WR : DATA_RD);
                    end else if (f_req) begin
                        r_base     <= f_addr[ADDR_W-1:0];
                        r_last     <= CNT_W'(3);
                        r_signed   <= 1'b0;
                        r_wdata    <= '0;
                        r_is_fetch <= 1'b1;
                        r_err      <= w_f_err;
                        r_state    <= w_f_err ? DONE : FETCH;
                    end
                end
                FETCH, DATA_RD, DATA_WR: begin
                    r_asm <= w_asm_next[23:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == r_last) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                        if (r_state == FETCH)   f_rdata <= w_ext;
                        if (r_state == DATA_RD) d_rdata <= w_ext;
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_we    = (r_state == DATA_WR);
    assign ram_addr  = w_access ? (r_base + ADDR_W'(r_cnt)) : '0;
    assign ram_wdata = ram_we ? w_wshift[7:0] : 8'h00;

    assign f_done = (r_state == DONE) && r_is_fetch;
    assign d_done = (r_state == DONE) && !r_is_fetch;
    assign f_err  = f_done && r_err;
    assign d_err  = d_done && r_err;
    assign busy   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// ============================================================================
//  Module   : tb_ram_access_ctrl
//  Brief    : Directed self-checking bench for ram_access_ctrl with a RAM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_access_ctrl;

    logic        main_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        f_req    = 1'b0;
    logic [31:0] f_addr   = '0;
    logic [31:0] f_rdata;
    logic        f_done, f_err;
    logic        d_req    = 1'b0;
    logic        d_we     = 1'b0;
    logic [1:0]  d_size   = '0;
    logic        d_signed = 1'b0;
    logic [31:0] d_addr   = '0;
    logic [31:0] d_wdata  = '0;
    logic [31:0] d_rdata;
    logic        d_done, d_err;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        busy;

    logic [7:0]  mem [0:511];
    int          tests = 0;
    int          fails = 0;

    always #5 main_clk = ~main_clk;

    always @(posedge main_clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    ram_access_ctrl #(.ADDR_W(9), .CNT_W(2)) dut (
        .main_clk(main_clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if ({f_rdata, f_done, f_err, d_rdata, d_done, d_err, ram_addr, ram_wdata, ram_we, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: f_rdata=%h d_rdata=%h ram_addr=%h busy=%b, required all 0",
                     f_rdata, d_rdata, ram_addr, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_word();
        mem[8] = 8'hE3; mem[9] = 8'hA0; mem[10] = 8'h10; mem[11] = 8'h05;
        f_req = 1'b1; f_addr = 32'd8;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (ram_addr !== 9'(8 + k) || ram_we !== 1'b0 || f_done !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL fetch_addr%0d: ram_addr=%0d we=%b done=%b busy=%b, required %0d 0 0 1",
                         k, ram_addr, ram_we, f_done, busy, 8 + k);
            end
        end
        tick();
        tests++;
        if (f_done !== 1'b1 || f_err !== 1'b0 || d_done !== 1'b0 || f_rdata !== 32'hE3A01005) begin
            fails++;
            $display("FAIL fetch_done: f_done=%b f_err=%b d_done=%b f_rdata=%h, required 1 0 0 e3a01005",
                     f_done, f_err, d_done, f_rdata);
        end
        f_req = 1'b0;
        tick();
        tests++;
        if (f_done !== 1'b0 || busy !== 1'b0 || ram_addr !== 9'd0) begin
            fails++;
            $display("FAIL fetch_idle: f_done=%b busy=%b ram_addr=%0d, required 0 0 0", f_done, busy, ram_addr);
        end
    endtask

    task automatic test_simultaneous();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h80;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b1; d_addr = 32'd3;
        f_req = 1'b1; f_addr = 32'd0;
        tick();
        tests++;
        if (ram_addr !== 9'd3) begin
            fails++;
            $display("FAIL simul_data_first: ram_addr=%0d, required 3", ram_addr);
        end
        tick();
        tests++;
        if (d_done !== 1'b1 || f_done !== 1'b0 || d_err !== 1'b0 || d_rdata !== 32'hFFFFFF80) begin
            fails++;
            $display("FAIL simul_data_done: d_done=%b f_done=%b d_err=%b d_rdata=%h, required 1 0 0 ffffff80",
                     d_done, f_done, d_err, d_rdata);
        end
        d_req = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL simul_idle_gap: busy=%b, required 0", busy);
        end
        repeat (5) tick();
        tests++;
        if (f_done !== 1'b1 || f_rdata !== 32'h11223380 || d_rdata !== 32'hFFFFFF80) begin
            fails++;
            $display("FAIL simul_fetch_done: f_done=%b f_rdata=%h d_rdata=%h, required 1 11223380 ffffff80",
                     f_done, f_rdata, d_rdata);
        end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_store_half();
        int we_cycles = 0;
        mem[20] = 8'h00; mem[21] = 8'h00; mem[22] = 8'h5A;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_signed = 1'b0; d_addr = 32'd20; d_wdata = 32'h0000ABCD;
        tick();
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== 9'd20 || ram_wdata !== 8'hAB) begin
            fails++;
            $display("FAIL store_byte0: we=%b addr=%0d wdata=%h, required 1 20 ab", ram_we, ram_addr, ram_wdata);
        end
        we_cycles += int'(ram_we);
        tick();
        tests++;
        if (ram_we !== 1'b1 || ram_addr !== 9'd21 || ram_wdata !== 8'hCD) begin
            fails++;
            $display("FAIL store_byte1: we=%b addr=%0d wdata=%h, required 1 21 cd", ram_we, ram_addr, ram_wdata);
        end
        we_cycles += int'(ram_we);
        tick();
        we_cycles += int'(ram_we);
        tests++;
        if (d_done !== 1'b1 || d_err !== 1'b0 || we_cycles != 2) begin
            fails++;
            $display("FAIL store_done: d_done=%b d_err=%b we_cycles=%0d, required 1 0 2", d_done, d_err, we_cycles);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        tests++;
        if (mem[20] !== 8'hAB || mem[21] !== 8'hCD || mem[22] !== 8'h5A) begin
            fails++;
            $display("FAIL store_ram: ram[20..22]=%h %h %h, required ab cd 5a", mem[20], mem[21], mem[22]);
        end
    endtask

    task automatic test_load_ext();
        logic        sg [2] = '{1'b1, 1'b0};
        logic [31:0] ex [2] = '{32'hFFFFABCD, 32'h0000ABCD};
        for (int i = 0; i < 2; i++) begin
            d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_signed = sg[i]; d_addr = 32'd20;
            repeat (3) tick();
            tests++;
            if (d_done !== 1'b1 || d_rdata !== ex[i]) begin
                fails++;
                $display("FAIL load_half_signed%0d: d_done=%b d_rdata=%h, required 1 %h", sg[i], d_done, d_rdata, ex[i]);
            end
            d_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [3] = '{2'b10, 2'b11, 2'b10};
        logic [31:0] ad [3] = '{32'd6, 32'd0, 32'h200};
        logic [31:0] keep;
        keep = d_rdata;
        for (int i = 0; i < 3; i++) begin
            d_req = 1'b1; d_we = 1'b0; d_size = sz[i]; d_signed = 1'b0; d_addr = ad[i];
            tick();
            tests++;
            if (d_done !== 1'b1 || d_err !== 1'b1 || ram_we !== 1'b0 || d_rdata !== keep || ram_addr !== 9'd0) begin
                fails++;
                $display("FAIL error_case%0d: done=%b err=%b we=%b d_rdata=%h ram_addr=%0d, required 1 1 0 %h 0",
                         i, d_done, d_err, ram_we, d_rdata, ram_addr, keep);
            end
            d_req = 1'b0; d_size = 2'b00;
            tick();
        end
        f_req = 1'b1; f_addr = 32'd2;
        tick();
        tests++;
        if (f_done !== 1'b1 || f_err !== 1'b1 || d_done !== 1'b0) begin
            fails++;
            $display("FAIL error_fetch: f_done=%b f_err=%b d_done=%b, required 1 1 0", f_done, f_err, d_done);
        end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int t_first = 0;
        int t_second = 0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'd8;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (d_done === 1'b1) begin
                n_done++;
                if (n_done == 1) t_first = c;
                if (n_done == 2) begin
                    t_second = c;
                    d_req = 1'b0;
                end
            end
        end
        tests++;
        if (n_done != 2 || t_first != 5 || t_second - t_first != 6 || d_rdata !== 32'hE3A01005) begin
            fails++;
            $display("FAIL back_to_back: pulses=%0d first=%0d gap=%0d d_rdata=%h, required 2 5 6 e3a01005",
                     n_done, t_first, t_second - t_first, d_rdata);
        end
    endtask

    task automatic test_reset_mid_store();
        int late_done = 0;
        for (int i = 40; i < 44; i++) mem[i] = 8'h00;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'd40; d_wdata = 32'h11223344;
        tick();
        tick();
        tests++;
        if (ram_addr !== 9'd41 || ram_we !== 1'b1) begin
            fails++;
            $display("FAIL rst_store_pre: ram_addr=%0d we=%b, required 41 1", ram_addr, ram_we);
        end
        reset = 1'b1;
        tick();
        d_req = 1'b0; d_we = 1'b0;
        tests++;
        if ({f_rdata, f_done, f_err, d_rdata, d_done, d_err, ram_addr, ram_wdata, ram_we, busy} !== '0) begin
            fails++;
            $display("FAIL rst_store_outputs: d_done=%b d_rdata=%h ram_we=%b ram_addr=%0d busy=%b, required all 0",
                     d_done, d_rdata, ram_we, ram_addr, busy);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            late_done += int'(d_done | ram_we);
        end
        tests++;
        if (late_done != 0 || mem[40] !== 8'h11 || mem[41] !== 8'h22 || mem[42] !== 8'h00 || mem[43] !== 8'h00) begin
            fails++;
            $display("FAIL rst_store_ram: late=%0d ram[40..43]=%h %h %h %h, required 0 11 22 00 00",
                     late_done, mem[40], mem[41], mem[42], mem[43]);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_fetch_word();
        test_simultaneous();
        test_store_half();
        test_load_ext();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 9, RAM byte-address width (512 bytes); CNT_W, default 2, byte-counter width.
REQ-002 Clock and reset SHALL be: main_clk input 1 (sole clock, rising edge); reset input 1 (synchronous, active-high).
REQ-003 Fetch port SHALL be: f_req input 1 (instruction-word read request); f_addr input 32 (byte address); f_rdata output 32 (fetched word); f_done output 1 (one-cycle completion pulse); f_err output 1 (one-cycle error pulse).
REQ-004 Data port SHALL be: d_req input 1; d_we input 1 (1=store); d_size input 2 (00 byte, 01 half, 10 word, 11 illegal); d_signed input 1 (sign-extend loads); d_addr input 32; d_wdata input 32; d_rdata output 32; d_done output 1; d_err output 1.
REQ-005 RAM side SHALL be: ram_addr output ADDR_W; ram_wdata output 8; ram_we output 1; ram_rdata input 8 (combinational read of ram_addr).
REQ-006 Status SHALL be: busy output 1 (high in any state other than IDLE).

Function
REQ-007 FSM states SHALL be IDLE, FETCH, DATA_RD, DATA_WR, DONE; req inputs SHALL be sampled only in IDLE.
REQ-008 In IDLE with d_req=1, the block SHALL grant the data port (priority over fetch); with only f_req=1 it SHALL grant fetch; simultaneous requests SHALL serve data first, fetch next when f_req is still high in IDLE.
REQ-009 At grant, the block SHALL latch address, size, we, signed and wdata; requester inputs SHALL be ignored until DONE.
REQ-010 Byte count N SHALL be 1/2/4 for size 00/01/10; fetch SHALL always be N=4.
REQ-011 Access states SHALL issue one RAM byte per cycle at ram_addr = base+k, k=0..N-1, with k held in a CNT_W-bit counter.
REQ-012 Byte order SHALL be big-endian: byte k=0 is most significant of the N-byte item.
REQ-013 Stores SHALL assert ram_we exactly N cycles; ram_wdata = byte (N-1-k) of d_wdata[8N-1:0].
REQ-014 Loads SHALL shift ram_rdata into an assembly register each access cycle; at DONE, d_rdata/f_rdata SHALL update, zero-extended, or sign-extended from bit 8N-1 when d_signed=1.
REQ-015 After the last byte the FSM SHALL enter DONE, pulse the granted port's done for exactly one cycle, then return to IDLE; latency from grant cycle to done = N+1 cycles.
REQ-016 Requesters SHALL drop req in the done cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-017 Error SHALL be flagged when size=11, when base is misaligned (half: addr[0]=1; word/fetch: addr[1:0]!=0), or when addr[31:ADDR_W]!=0.
REQ-018 On error the FSM SHALL go IDLE->DONE with no RAM access (ram_we=0), pulse done and err together, and leave rdata unchanged.
REQ-019 d_rdata and f_rdata SHALL hold their values until that port's next successful load.
REQ-020 Outside access states ram_we SHALL be 0; ram_addr/ram_wdata SHALL be 0 in IDLE and DONE.
REQ-021 base+k SHALL never wrap, since REQ-017 guarantees in-range aligned bases.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, clear counter and latches, and set all outputs to 0 on the following cycle.
REQ-023 Reset mid-access SHALL abort: no further ram_we, no done/err pulse; bytes already written remain in RAM.
REQ-024 Reset SHALL take priority over every request and state transition.

Verification
REQ-025 Fetch word: RAM[8..11]=E3,A0,10,05; f_req, f_addr=8 -> ram_addr 8,9,10,11 on cycles 1-4, f_done on cycle 5, f_rdata=E3A01005.
REQ-026 Simultaneous: d_req load byte addr 3 (RAM=80, d_signed=1) and f_req addr 0 -> data serviced first, d_rdata=FFFFFF80, d_done at cycle 2; fetch starts next IDLE, f_done 5 cycles later.
REQ-027 Store half: d_we=1, size=01, addr=20, wdata=0000ABCD -> RAM[20]=AB, RAM[21]=CD, ram_we high exactly 2 cycles, d_done at cycle 3.
REQ-028 Errors: word load addr=6 -> d_err+d_done at cycle 1, ram_we=0, d_rdata unchanged; size=11 and addr=0x200 same response.
REQ-029 Reset mid-store: word store addr 40, reset asserted after 2nd byte -> RAM[40..41] written, RAM[42..43] unchanged, no d_done, all outputs 0, busy=0 next cycle.
REQ-030 Back-to-back: d_req held high across done -> second access granted in the IDLE cycle right after DONE, done pulses separated by N+2 cycles.
